serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial add sequencer. It time-multiplexes a single 1-bit full-adder cell across WIDTH bit positions to produce the same result as a WIDTH-bit ripple-carry adder (A + B + Cin).
- Captures both operands through a valid/ready request handshake.
- Walks the adder LSB-first with a registered carry, one bit per clock.
- Presents the sum and carry-out through a valid/ready result handshake.
- Used where adder area matters more than latency.

Parameters:
WIDTH, 4, operand/sum width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-index counter width; derived, do not override.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start_valid  input  1  requester has operands on a_in/b_in/cin
start_ready  output  1  block can accept an operation
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
cin  input  1  carry-in to bit 0
sum_out  output  WIDTH  last completed sum, registered
cout  output  1  last completed carry-out of bit WIDTH-1, registered
done_valid  output  1  sum_out/cout hold a fresh result
done_ready  input  1  consumer accepts result
busy  output  1  high in RUN or DONE
bit_idx  output  CNT_W  bit position being added in RUN; 0 otherwise

Behaviour:
- Reset (rst_n=0 at a clock edge) wins over all other inputs in that cycle. Required values on the next edge:
  - State goes to IDLE.
  - start_ready=1; done_valid=0; busy=0; bit_idx=0.
  - sum_out=0; cout=0.
  - Internal shift registers and carry are cleared.
- Reset in the middle of an operation aborts it. No partial result is ever published.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: load a_sh=a_in, b_sh=b_in, carry=cin, acc=0, bit_idx=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, one bit per cycle:
  - s = a_sh[0]^b_sh[0]^carry.
  - c = (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
  - Right-shift a_sh and b_sh. acc = {s, acc[WIDTH-1:1]}. carry = c.
  - bit_idx increments by 1.
  - When bit_idx==WIDTH-1: register sum_out = final acc including this s, register cout = c, then go to DONE.
  - start_ready=0 throughout RUN; start_valid is ignored.
- Latency: with the accept edge at T0, done_valid is first high after edge T_WIDTH (WIDTH RUN cycles).
- DONE:
  - done_valid=1; sum_out/cout are stable.
  - Stay in DONE while done_ready=0, holding all outputs. There is no timeout.
  - On done_ready=1: done_valid drops at the next edge and the FSM returns to IDLE.
  - start_ready=0 in DONE. The next operation is accepted no earlier than the first IDLE cycle, so minimum issue interval is WIDTH+2 cycles.
- sum_out/cout hold the last completed result through IDLE and RUN of the next operation. They change only on the RUN→DONE transition.
- Arithmetic is modulo 2^WIDTH with the carry exported on cout. cin only affects bit 0.
- bit_idx wraps to 0 on leaving RUN and never reaches WIDTH.
- Handshake rules:
  - A request is accepted only when start_valid and start_ready are both high at an edge. Operands are sampled at that edge only, so later changes to a_in/b_in/cin do not affect the operation.
  - done_valid never deasserts without done_ready, except on reset.
- No X propagation: every register is reset.

Test Plan:
1. Reset, then WIDTH=4: a_in=0000, b_in=0000, cin=0, start_valid one cycle → done_valid high exactly 4 cycles after the accept edge; sum_out=0000, cout=0.
2. a_in=0110, b_in=1010, cin=0; done_ready tied 1 → sum_out=0000, cout=1; done_valid high for one cycle; start_ready back to 1 on the following cycle.
3. a_in=1011, b_in=1111, cin=1 → sum_out=1011, cout=1. Check bit_idx steps 0,1,2,3 during RUN.
4. Backpressure: a_in=0101, b_in=0011, cin=1 (sum 1001, cout 0), done_ready=0 for 6 cycles → done_valid, sum_out and cout stable for all 6 cycles. Raise done_ready → done_valid=0 next edge.
5. Request during busy: assert start_valid with a_in=1111, b_in=0001 during RUN of the op in scenario 2 → ignored (start_ready=0). Result is still 0000/1, and the second op is accepted only after DONE→IDLE.
6. Reset mid-RUN: pull rst_n low at bit_idx=2 → next edge: IDLE, busy=0, done_valid=0, sum_out=0000, cout=0. A fresh op then completes normally.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add sequencer. One 1-bit full-adder cell is reused across
//   WIDTH bit positions, LSB first, with the carry held in a register
//   between cycles. The result equals a WIDTH-bit ripple-carry adder
//   computing A + B + Cin, with the carry out of bit WIDTH-1 on cout.
//
// Handshakes (valid/ready on both sides):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. A producer keeps its valid and payload steady until that edge. A
//   consumer may change ready at any time. The block never drops done_valid
//   without done_ready, except on reset.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start_valid  requester presents a_in/b_in/cin
//   start_ready  block is idle and can accept an operation
//   a_in, b_in   operands (WIDTH bits)
//   cin          carry into bit 0
//   sum_out      last completed sum (registered)
//   cout         last completed carry-out (registered)
//   done_valid   sum_out/cout hold a result not yet taken
//   done_ready   consumer takes the result
//   busy         high while an operation is running or its result is pending
//   bit_idx      bit position being added during RUN, 0 otherwise
//   dbg_state    current FSM state (debug)
module serial_adder_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_idx,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_bit_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_a_sh_nxt;
    logic [WIDTH-1:0] w_b_sh_nxt;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_bit_idx_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cout_nxt;

    // Single full-adder cell working on the current LSBs.
    logic             w_s;
    logic             w_c;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_acc_shift;

    assign w_s         = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c         = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
    assign w_last_bit  = (r_bit_idx == CNT_W'(WIDTH - 1));
    // Sum bits enter at the MSB and move down, so after WIDTH shifts the
    // first (bit 0) sum bit sits at acc[0].
    assign w_acc_shift = {w_s, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_carry   <= 1'b0;
            r_acc     <= '0;
            r_bit_idx <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a_sh    <= w_a_sh_nxt;
            r_b_sh    <= w_b_sh_nxt;
            r_carry   <= w_carry_nxt;
            r_acc     <= w_acc_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_sum     <= w_sum_nxt;
            r_cout    <= w_cout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_a_sh_nxt    = r_a_sh;
        w_b_sh_nxt    = r_b_sh;
        w_carry_nxt   = r_carry;
        w_acc_nxt     = r_acc;
        w_bit_idx_nxt = r_bit_idx;
        w_sum_nxt     = r_sum;
        w_cout_nxt    = r_cout;

        case (r_state)
            S_IDLE: begin
                w_bit_idx_nxt = '0;
                if (start_valid) begin
                    w_a_sh_nxt  = a_in;
                    w_b_sh_nxt  = b_in;
                    w_carry_nxt = cin;
                    w_acc_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_a_sh_nxt  = r_a_sh >> 1;
                w_b_sh_nxt  = r_b_sh >> 1;
                w_acc_nxt   = w_acc_shift;
                w_carry_nxt = w_c;
                if (w_last_bit) begin
                    // Publish the full result only here, so an aborted
                    // operation never leaks a partial sum.
                    w_sum_nxt     = w_acc_shift;
                    w_cout_nxt    = w_c;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_bit_idx_nxt = r_bit_idx + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_bit_idx_nxt = '0;
                if (done_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_bit_idx_nxt = '0;
            end
        endcase
    end

    assign start_ready = (r_state == S_IDLE);
    assign done_valid  = (r_state == S_DONE);
    assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
    assign bit_idx     = r_bit_idx;
    assign sum_out     = r_sum;
    assign cout        = r_cout;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH);

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             done_valid;
    logic             done_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] bit_idx;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin         (cin),
        .sum_out     (sum_out),
        .cout        (cout),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy),
        .bit_idx     (bit_idx),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH:0] exp_q[$];            // {cout, sum} per accepted op
    logic [WIDTH-1:0] pub_sum = '0;      // last published result
    logic             pub_cout = 1'b0;

    // Reference: plain integer addition, split into sum and carry-out.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic c);
        int total;
        total = int'(a) + int'(b) + int'(c);
        ref_add = {total >= (1 << WIDTH), WIDTH'(total % (1 << WIDTH))};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_published(input string tag);
        check({tag, "_sum"},  64'(sum_out), 64'(pub_sum));
        check({tag, "_cout"}, 64'(cout),    64'(pub_cout));
    endtask

    // Runs one operation end to end. hold = cycles of done_ready=0 in DONE.
    // inject = drive a competing request while RUN is in progress.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input int hold, input bit inject);
        logic [WIDTH:0] e;
        check("idle_start_ready", 64'(start_ready), 64'(1));
        start_valid = 1'b1;
        a_in = a;
        b_in = b;
        cin  = c;
        done_ready = (hold == 0);
        exp_q.push_back(ref_add(a, b, c));
        tick();                                   // accept edge T0
        start_valid = inject;
        a_in = inject ? '1 : WIDTH'($urandom);
        b_in = inject ? WIDTH'(1) : WIDTH'($urandom);
        cin  = 1'($urandom);
        check("run_start_ready", 64'(start_ready), 64'(0));
        check("run_busy", 64'(busy), 64'(1));
        check("run_bit_idx0", 64'(bit_idx), 64'(0));
        for (int k = 1; k < WIDTH; k++) begin
            tick();
            if (k == WIDTH - 1) start_valid = 1'b0;
            check("run_bit_idx", 64'(bit_idx), 64'(k));
            check("run_done_valid", 64'(done_valid), 64'(0));
            check_published("run_hold");
        end
        tick();                                   // edge T_WIDTH
        e = exp_q.pop_front();
        pub_sum  = e[WIDTH-1:0];
        pub_cout = e[WIDTH];
        check("done_valid", 64'(done_valid), 64'(1));
        check("done_bit_idx", 64'(bit_idx), 64'(0));
        check_published("done");
        for (int k = 0; k < hold; k++) begin
            tick();
            check("bp_done_valid", 64'(done_valid), 64'(1));
            check_published("bp");
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("post_done_valid", 64'(done_valid), 64'(0));
        check("post_start_ready", 64'(start_ready), 64'(1));
        check("post_busy", 64'(busy), 64'(0));
        check_published("post");
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_start_ready"}, 64'(start_ready), 64'(1));
        check({tag, "_done_valid"},  64'(done_valid),  64'(0));
        check({tag, "_busy"},        64'(busy),        64'(0));
        check({tag, "_bit_idx"},     64'(bit_idx),     64'(0));
        check({tag, "_sum"},         64'(sum_out),     64'(0));
        check({tag, "_cout"},        64'(cout),        64'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // 1: zero operands, latency
        run_op(4'b0000, 4'b0000, 1'b0, 0, 1'b0);
        // 2: overflow to zero with carry, done_ready tied high
        run_op(4'b0110, 4'b1010, 1'b0, 0, 1'b0);
        // 3: all carries, bit_idx stepping
        run_op(4'b1011, 4'b1111, 1'b1, 0, 1'b0);
        // 4: backpressure
        run_op(4'b0101, 4'b0011, 1'b1, 6, 1'b0);
        // 5: request during RUN must be ignored
        run_op(4'b0110, 4'b1010, 1'b0, 0, 1'b1);
        tick();
        check("no_late_accept_busy", 64'(busy), 64'(0));
        run_op(4'b1111, 4'b0001, 1'b0, 0, 1'b0);

        // 6: reset in the middle of RUN
        start_valid = 1'b1;
        a_in = 4'b1001;
        b_in = 4'b0111;
        cin  = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        check("mid_bit_idx", 64'(bit_idx), 64'(2));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pub_sum  = '0;
        pub_cout = 1'b0;
        check_reset_state("midrst");
        tick();
        check_reset_state("midrst_idle");
        run_op(4'b1001, 4'b0111, 1'b1, 1, 1'b0);

        // random operations
        for (int i = 0; i < 30; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
